// File: rtl/isa_pkg.sv
// Shared instruction-format definitions for the core.
// The decode stage and the program-load encoder both import this package,
// so the two sides of the instruction format can never drift apart.
// Contents:
//   FMT_*          2-bit format codes carried alongside decoded fields
//   *_MSB / *_W    bit positions and widths of each field in the 32-bit word
//   load_state_t   state encoding of the IMEM program-load FSM
package isa_pkg;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_J   = 2'b10;
  localparam logic [1:0] FMT_ILL = 2'b11;

  localparam int OP_MSB  = 31;
  localparam int RS_MSB  = 27;
  localparam int RT_MSB  = 22;
  localparam int RD_MSB  = 17;
  localparam int IMM_MSB = 15;
  localparam int JA_MSB  = 25;

  localparam int OP_W  = 4;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;
  localparam int JA_W  = 26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } load_state_t;

endpackage

// File: rtl/instruction_encoder_loader_pack.sv
// instr_pack: purely combinational encoder from decoded fields to a 32-bit
// instruction word. It is the inverse of the decode stage's field extraction.
// Ports:
//   fmt      in   2   format select (R/I/J/illegal)
//   opcode   in   4   opcode field
//   rs       in   5   source register 1
//   rt       in   5   source register 2 / I-type target
//   rd       in   5   R-type destination
//   imm      in   16  I-type immediate
//   jaddr    in   26  J-type jump address
//   word     out  32  encoded word, all unused bits zero
//   illegal  out  1   fmt was the reserved illegal code
module instr_pack
  import isa_pkg::*;
(
  input  logic [1:0]       fmt,
  input  logic [OP_W-1:0]  opcode,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  input  logic [IMM_W-1:0] imm,
  input  logic [JA_W-1:0]  jaddr,
  output logic [31:0]      word,
  output logic             illegal
);

  // Start from an all-zero word so every bit a format does not use stays 0,
  // then drop each field into its slot for the selected format.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        word[OP_MSB -: OP_W]  = opcode;
        word[RS_MSB -: REG_W] = rs;
        word[RT_MSB -: REG_W] = rt;
        word[RD_MSB -: REG_W] = rd;
      end
      FMT_I: begin
        word[OP_MSB -: OP_W]   = opcode;
        word[RS_MSB -: REG_W]  = rs;
        word[RT_MSB -: REG_W]  = rt;
        word[IMM_MSB -: IMM_W] = imm;
      end
      FMT_J: begin
        word[OP_MSB -: OP_W] = opcode;
        word[JA_MSB -: JA_W] = jaddr;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader: program-load path into instruction memory.
// A host streams decoded field tuples in; each legal tuple is encoded and
// written to IMEM at consecutive word addresses starting from BASE_ADDR.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  open a load session (only honoured in IDLE)
//   in_valid/in_ready      tuple handshake
//   in_fmt..in_jaddr       decoded instruction fields
//   in_last                final tuple of the session
//   mem_we/mem_addr/
//   mem_wdata/mem_ready    IMEM write port, request held until mem_ready
//   busy                   session in progress (LOAD or DRAIN)
//   done                   one-cycle pulse at session end
//   err_fmt / err_ovf      sticky per-session error flags
//   word_count             words committed to IMEM this session
module instruction_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [3:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_jaddr,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_fmt,
  output logic              err_ovf,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE      = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   DEPTH_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] ADDR_INC  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_INC   = {{ADDR_W{1'b0}}, 1'b1};

  load_state_t       state;
  load_state_t       next_state;
  logic [ADDR_W:0]   accepted_cnt;
  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              accept;
  logic              commit;
  logic              cnt_full;
  logic              ovf_hit;

  instr_pack u_pack (
    .fmt     (in_fmt),
    .opcode  (in_opcode),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .jaddr   (in_jaddr),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // accepted_cnt counts every accepted tuple, legal or not, so the session
  // budget is about tuples taken from the host rather than words written.
  assign accept   = in_valid & in_ready;
  assign commit   = mem_we & mem_ready;
  assign cnt_full = (accepted_cnt >= DEPTH_CNT);
  assign ovf_hit  = (state == ST_LOAD) & in_valid & cnt_full;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. An overflowing offer ends the session just like
  // in_last would, so the host is not left waiting on a full loader.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if ((accept & in_last) | ovf_hit) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!mem_we) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state. in_ready also opens when the held word is
  // committing this cycle, which keeps a full one-word-per-cycle stream.
  always_comb begin
    in_ready = (state == ST_LOAD) & (~mem_we | mem_ready) & ~cnt_full;
    busy     = (state == ST_LOAD) | (state == ST_DRAIN);
    done     = (state == ST_DONE);
  end

  // Single-stage output register. A legal accept loads the next word even
  // if the previous one commits on the same edge; an illegal accept leaves
  // mem_we/mem_addr untouched apart from finishing an in-flight commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (accept && !pack_illegal) begin
      mem_we    <= 1'b1;
      mem_wdata <= pack_word;
    end else if (commit) begin
      mem_we    <= 1'b0;
    end
  end

  // Session counters and sticky error flags, cleared when a new session
  // opens so results stay readable in IDLE after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr     <= BASE;
      word_count   <= '0;
      accepted_cnt <= '0;
      err_fmt      <= 1'b0;
      err_ovf      <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      mem_addr     <= BASE;
      word_count   <= '0;
      accepted_cnt <= '0;
      err_fmt      <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      if (commit) begin
        mem_addr   <= mem_addr + ADDR_INC;
        word_count <= word_count + CNT_INC;
      end
      if (accept) begin
        accepted_cnt <= accepted_cnt + CNT_INC;
        if (pack_illegal) err_fmt <= 1'b1;
      end
      if (ovf_hit) err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Self-checking bench for instruction_encoder_loader (DEPTH=4 so that the
// overflow case is reachable). A queue of expected IMEM writes is built from
// the tuples the bench hands over; a negedge monitor checks every offered
// write and the running word_count against it.
module tb_instruction_encoder_loader;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [3:0]        in_opcode;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_jaddr;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              err_fmt;
  logic              err_ovf;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  instruction_encoder_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_jaddr   (in_jaddr),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .err_fmt    (err_fmt),
    .err_ovf    (err_ovf),
    .word_count (word_count)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  model_wc = 0;
  int  model_next = 0;
  int  done_count = 0;

  // Reference encoding written as weighted field sums.
  function automatic logic [31:0] model_word(input logic [1:0] fmt, input logic [3:0] op,
                                             input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [15:0] imm,
                                             input logic [25:0] ja);
    longint w;
    w = 0;
    if (fmt == 2'b00)
      w = longint'(op) * 268435456 + longint'(rs) * 8388608 + longint'(rt) * 262144
        + longint'(rd) * 8192;
    else if (fmt == 2'b01)
      w = longint'(op) * 268435456 + longint'(rs) * 8388608 + longint'(rt) * 262144
        + longint'(imm);
    else if (fmt == 2'b10)
      w = longint'(op) * 268435456 + longint'(ja);
    return w[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle outside reset: word_count must match commits seen so far, and
  // any offered write must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("word_count_run", 32'(word_count), 32'(model_wc));
      if (done) done_count++;
      if (mem_we) begin
        checkOutput("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          checkOutput("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
          checkOutput("mem_wdata", mem_wdata, exp_q[0].data);
          if (mem_ready) begin
            void'(exp_q.pop_front());
            model_wc++;
          end
        end
      end
    end
  end

  // Offer one tuple, wait for acceptance, and record the write it implies.
  task automatic applyStimulus(input logic [1:0] fmt, input logic [3:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                               input logic [25:0] ja, input logic last);
    logic acc;
    acc = 1'b0;
    in_fmt = fmt; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_jaddr = ja; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    checkOutput("accept_in_time", 32'(acc), 32'd1);
    if (acc && fmt != 2'b11) begin
      exp_q.push_back('{addr: 8'(BASE_ADDR + model_next), data: model_word(fmt, op, rs, rt, rd, imm, ja)});
      model_next++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic offerRejected();
    in_fmt = 2'b00; in_opcode = 4'h7; in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("ovf_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic startSession();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.delete();
    model_wc   = 0;
    model_next = 0;
    done_count = 0;
  endtask

  // Literal pin on the word written one cycle after the last accept.
  task automatic pinWord(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    checkOutput("pin_we", 32'(mem_we), 32'd1);
    checkOutput("pin_addr", 32'(mem_addr), addr);
    checkOutput("pin_data", mem_wdata, data);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int wc, input logic efmt, input logic eovf);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("word_count_end", 32'(word_count), 32'(wc));
    checkOutput("err_fmt", 32'(err_fmt), 32'(efmt));
    checkOutput("err_ovf", 32'(err_ovf), 32'(eovf));
    checkOutput("busy_end", 32'(busy), 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("done_pulses", 32'(done_count), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(BASE_ADDR));
    checkOutput({tag, "_word_count"}, 32'(word_count), 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_errs"}, {30'd0, err_fmt, err_ovf}, 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
    in_fmt = 2'b00; in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm = '0; in_jaddr = '0;

    // Reset values.
    @(negedge clk);
    checkIdleReset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // R, I, J packing with literal expectations.
    $display("[TB] R/I/J packing");
    startSession();
    applyStimulus(2'b00, 4'h3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    pinWord(32'd0, 32'h3088_6000);
    applyStimulus(2'b01, 4'h5, 5'd31, 5'd0, 5'd0, 16'hBEEF, 26'h0, 1'b0);
    pinWord(32'd1, 32'h5F80_BEEF);
    applyStimulus(2'b10, 4'h9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b1);
    pinWord(32'd2, 32'h93FF_FFFF);
    waitDone(3, 1'b0, 1'b0);

    // Backpressure on the second word.
    $display("[TB] backpressure");
    startSession();
    applyStimulus(2'b00, 4'h1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
    applyStimulus(2'b01, 4'hA, 5'd7, 5'd8, 5'd0, 16'h1234, 26'h0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_addr", 32'(mem_addr), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    applyStimulus(2'b10, 4'hC, 5'd0, 5'd0, 5'd0, 16'h0, 26'h155_5555, 1'b0);
    applyStimulus(2'b00, 4'hF, 5'd31, 5'd31, 5'd31, 16'h0, 26'h0, 1'b1);
    waitDone(4, 1'b0, 1'b0);

    // Illegal format in the middle.
    $display("[TB] illegal format");
    startSession();
    applyStimulus(2'b01, 4'h2, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'h0, 1'b0);
    applyStimulus(2'b11, 4'h6, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
    applyStimulus(2'b00, 4'h4, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0, 1'b1);
    waitDone(2, 1'b1, 1'b0);

    // Overflow beyond DEPTH with no in_last.
    $display("[TB] overflow");
    startSession();
    applyStimulus(2'b00, 4'h1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
    applyStimulus(2'b01, 4'h2, 5'd2, 5'd2, 5'd0, 16'h0002, 26'h0, 1'b0);
    applyStimulus(2'b10, 4'h3, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0003, 1'b0);
    applyStimulus(2'b00, 4'h4, 5'd4, 5'd4, 5'd4, 16'h0, 26'h0, 1'b0);
    offerRejected();
    offerRejected();
    waitDone(4, 1'b0, 1'b1);

    // Reset while a write is stuck in DRAIN.
    $display("[TB] reset mid-drain");
    startSession();
    mem_ready = 1'b0;
    applyStimulus(2'b00, 4'h8, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b1);
    @(negedge clk);
    checkOutput("drain_busy", 32'(busy), 32'd1);
    checkOutput("drain_we_held", 32'(mem_we), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    model_wc   = 0;
    model_next = 0;
    @(negedge clk);
    checkIdleReset("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("after_reset_we", 32'(mem_we), 32'd0);
    checkOutput("after_reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    startSession();
    applyStimulus(2'b10, 4'hE, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0AB_CDEF, 1'b1);
    pinWord(32'd0, 32'hE0AB_CDEF);
    waitDone(1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
